// File: rtl/nios_v1_tx_mailbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nios_v1_tx_mailbox
// Description : Avalon-MM slave that lets Nios push words into a small FIFO
//               drained by fabric logic over a valid/ready handshake.
//               Provides status, a level interrupt, flush and a sticky
//               overflow flag.
// Ports       : clk, reset         - clock / async active-high reset
//               address, chipselect, write_n, writedata, readdata
//                                   - Avalon-MM register window
//                                     (0 DATA, 1 STATUS, 2 CTRL, 3 OVFCLR)
//               out_data, out_valid, out_ready
//                                   - FIFO head stream to the consumer
//               irq                 - level interrupt (empty | overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module nios_v1_tx_mailbox #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);

    localparam int                    c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_FULL    = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    localparam logic [1:0] c_ADDR_DATA   = 2'd0;
    localparam logic [1:0] c_ADDR_STATUS = 2'd1;
    localparam logic [1:0] c_ADDR_CTRL   = 2'd2;
    localparam logic [1:0] c_ADDR_OVFCLR = 2'd3;

    logic [DATA_W-1:0]     r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovf;
    logic                  r_irq_en;
    logic                  r_irq;
    logic [31:0]           r_readdata;

    logic                  w_wr;
    logic                  w_wr_data;
    logic                  w_flush;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ovf_set;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic                  w_ovf_nxt;
    logic                  w_irq_en_nxt;
    logic [31:0]           w_rdata;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_data = w_wr & (address == c_ADDR_DATA);
    assign w_flush   = w_wr & (address == c_ADDR_CTRL) & writedata[1];

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_pop_req = ~w_empty & out_ready;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted. Flush discards both sides of the transfer.
    assign w_push    = w_wr_data & (~w_full | w_pop_req) & ~w_flush;
    assign w_pop     = w_pop_req & ~w_flush;
    assign w_ovf_set = w_wr_data & w_full & ~w_pop_req & ~w_flush;

    always_comb begin
        w_count_nxt = r_count;
        if (w_flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    assign w_ovf_nxt    = w_ovf_set ? 1'b1 :
                          (w_wr && (address == c_ADDR_OVFCLR) && writedata[0]) ? 1'b0 :
                          r_ovf;
    assign w_irq_en_nxt = (w_wr && (address == c_ADDR_CTRL)) ? writedata[0] : r_irq_en;

    // Head word is pointer-derived so it never depends on writedata directly.
    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign readdata  = r_readdata;
    assign irq       = r_irq;

    // Read mux samples pre-edge state; reloaded every cycle.
    always_comb begin
        w_rdata = '0;
        case (address)
            c_ADDR_DATA:   w_rdata[DATA_W-1:0] = out_data;
            c_ADDR_STATUS: begin
                w_rdata[DEPTH_LOG2:0] = r_count;
                w_rdata[16]           = w_empty;
                w_rdata[17]           = w_full;
                w_rdata[18]           = r_ovf;
            end
            c_ADDR_CTRL:   w_rdata[0] = r_irq_en;
            default:       w_rdata = '0;
        endcase
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= writedata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_irq_en   <= 1'b0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
            r_count    <= w_count_nxt;
            r_ovf      <= w_ovf_nxt;
            r_irq_en   <= w_irq_en_nxt;
            r_irq      <= w_irq_en_nxt & ((w_count_nxt == '0) | w_ovf_nxt);
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_v1_tx_mailbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_nios_v1_tx_mailbox
// Description : Self-checking bench for nios_v1_tx_mailbox. Accepted pushes
//               are queued as expected words and compared as the consumer
//               handshakes them; register reads are checked against a small
//               model of count / overflow / irq_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_v1_tx_mailbox;

    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 2;
    localparam int c_DEPTH    = 1 << DEPTH_LOG2;

    logic              clk;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              irq;

    nios_v1_tx_mailbox #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops   = 0;
    int          n_pushes = 0;
    logic [31:0] exp_q [$];
    logic        exp_ovf    = 1'b0;
    logic        exp_irq_en = 1'b0;
    logic        tb_flush   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s       = '0;
        s[4:0]  = 5'(exp_q.size());
        s[16]   = (exp_q.size() == 0);
        s[17]   = (exp_q.size() == c_DEPTH);
        s[18]   = exp_ovf;
        return s;
    endfunction

    function automatic logic exp_irq();
        return exp_irq_en & ((exp_q.size() == 0) | exp_ovf);
    endfunction

    // Consumer side: every handshake must deliver the oldest queued word.
    always @(negedge clk) begin
        if (!reset && !tb_flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("pop_with_empty_model", 32'(out_data), 32'hxxxx_xxxx);
            end else begin
                check_eq("pop_data", 32'(out_data), exp_q.pop_front());
                n_pops++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic av_write(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        case (addr)
            2'd0: begin
                if ((exp_q.size() < c_DEPTH) || (out_ready && exp_q.size() > 0)) begin
                    exp_q.push_back(data);
                    n_pushes++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            2'd2: begin
                exp_irq_en = data[0];
                tb_flush   = data[1];
            end
            2'd3: if (data[0]) exp_ovf = 1'b0;
            default: ;
        endcase
        tick();
        if (tb_flush) begin
            exp_q.delete();
            tb_flush = 1'b0;
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
        check_eq(tag, readdata, exp);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        out_ready = 1'b0;
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        out_ready  = 1'b0;
        repeat (3) tick();
        check_eq("rst_readdata", readdata, 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        tick();
        check_eq("idle_readdata", readdata, 32'd0);
        rd_chk("status_idle", 2'd1, 32'h0001_0000);

        // Fill, then overflow with no pop.
        for (int i = 1; i <= 4; i++) av_write(2'd0, 32'(i * 'h11));
        rd_chk("status_full", 2'd1, 32'h0002_0004);
        check_eq("head_full", 32'(out_data), 32'h11);
        rd_chk("data_read", 2'd0, 32'h11);
        av_write(2'd0, 32'h55);
        rd_chk("status_ovf", 2'd1, 32'h0006_0004);
        check_eq("head_after_ovf", 32'(out_data), 32'h11);

        // Drain four words.
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check_eq("valid_drained", 32'(out_valid), 32'd0);
        check_eq("out_data_empty", 32'(out_data), 32'd0);
        rd_chk("status_empty_ovf", 2'd1, 32'h0005_0000);
        av_write(2'd3, 32'h1);
        rd_chk("status_ovfclr", 2'd1, exp_status());
        rd_chk("ovfclr_read", 2'd3, 32'd0);

        // Push into a full FIFO alongside a pop.
        for (int i = 1; i <= 4; i++) av_write(2'd0, 32'(i * 'h11));
        out_ready = 1'b1;
        av_write(2'd0, 32'h66);
        out_ready = 1'b0;
        rd_chk("status_push_pop_full", 2'd1, 32'h0002_0004);
        drain("drain_push_pop");
        check_eq("no_ovf_push_pop", 32'(exp_ovf), 32'd0);

        // Pointer wrap with random consumer pacing, including overflows.
        for (int i = 0; i < 24; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            av_write(2'd0, $urandom);
        end
        rd_chk("status_random", 2'd1, exp_status());
        drain("drain_random");
        check_eq("pushes_eq_pops", 32'(n_pops), 32'(n_pushes));
        av_write(2'd3, 32'h1);
        rd_chk("status_after_wrap", 2'd1, 32'h0001_0000);

        // Interrupt behaviour.
        av_write(2'd2, 32'h1);
        check_eq("irq_en_empty", 32'(irq), 32'(exp_irq()));
        check_eq("irq_en_empty_abs", 32'(irq), 32'd1);
        av_write(2'd0, 32'h77);
        check_eq("irq_after_push", 32'(irq), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("irq_after_pop", 32'(irq), 32'd1);
        rd_chk("ctrl_read", 2'd2, 32'h1);
        av_write(2'd2, 32'h0);
        check_eq("irq_disabled", 32'(irq), 32'd0);

        // Flush with a pending pop and sticky overflow set.
        for (int i = 0; i < 5; i++) av_write(2'd0, 32'hA0 + 32'(i));
        out_ready = 1'b1;
        av_write(2'd2, 32'h3);
        out_ready = 1'b0;
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        check_eq("flush_irq", 32'(irq), 32'd1);
        rd_chk("flush_status", 2'd1, 32'h0005_0000);
        rd_chk("flush_ctrl", 2'd2, 32'h1);
        check_eq("flush_no_pop", 32'(n_pops), 32'(n_pushes - 4));

        // Asynchronous reset in the middle of traffic.
        av_write(2'd3, 32'h1);
        for (int i = 0; i < 3; i++) av_write(2'd0, 32'hC0 + 32'(i));
        address = 2'd1;
        #2;
        reset = 1'b1;
        #2;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_data", 32'(out_data), 32'd0);
        check_eq("arst_readdata", readdata, 32'd0);
        check_eq("arst_irq", 32'(irq), 32'd0);
        exp_q.delete();
        exp_ovf    = 1'b0;
        exp_irq_en = 1'b0;
        tick();
        reset = 1'b0;
        rd_chk("status_post_arst", 2'd1, 32'h0001_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios_v1_tx_mailbox.md
Name: nios_v1_tx_mailbox

Overview:
Avalon-MM slave, Nios-side writer, feeding a FIFO-buffered word stream to fabric/ReCOP logic over a valid/ready handshake.
- Outbound counterpart of the single-bit input PIO that reads peak-detect status into Nios.
- Nios pushes words through a register window. Downstream logic pops them.
- Status, level interrupt, flush and sticky overflow let software pace itself without polling fabric signals.

Parameters:
DATA_W, 32, width of each pushed word and of out_data (1..32).
DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 entries (1..4, i.e. 2..16 entries).

Ports:
clk  input  1  system clock, all logic rising-edge.
reset  input  1  asynchronous, active-high reset.
address  input  2  Avalon register select.
chipselect  input  1  Avalon slave select.
write_n  input  1  Avalon write strobe, active-low; write occurs when chipselect=1 and write_n=0.
writedata  input  32  Avalon write data.
readdata  output  32  Avalon read data, registered.
out_data  output  DATA_W  FIFO head word.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head word this cycle.
irq  output  1  level interrupt to Nios.

Behaviour:
- Reset (async, active-high):
  - FIFO pointers and count = 0.
  - out_valid = 0; out_data = 0.
  - readdata = 0; irq = 0; irq_en = 0; overflow = 0.
- Register map:
  - addr0 DATA:
    - W: push writedata[DATA_W-1:0].
    - R: current head word zero-extended, or 0 if empty.
  - addr1 STATUS (R only):
    - [4:0] count, zero-extended.
    - [16] empty; [17] full; [18] overflow.
    - Other bits 0. Writes ignored.
  - addr2 CTRL:
    - [0] irq_en, R/W.
    - [1] flush: write-1 pulse, reads 0.
  - addr3 OVFCLR:
    - W with writedata[0]=1 clears overflow.
    - R returns 0.
- Read timing:
  - readdata is reloaded every clk from the address mux, regardless of chipselect.
  - Fixed read latency 1 cycle, zero wait states.
  - Value reflects state before the same edge's updates.
- Push:
  - Accepted when a DATA write occurs and (not full, or a pop occurs in the same cycle).
  - Accepted word is stored at the tail; count increments.
  - Push while full with no simultaneous pop: word dropped, overflow set (sticky), count unchanged.
- Pop:
  - Occurs when out_valid=1 and out_ready=1 in the same cycle; head advances, count decrements.
  - out_ready while empty has no effect.
- Simultaneous push+pop: count unchanged; both pointers advance.
- Timing:
  - Push-to-valid latency: word written at edge N is visible, with out_valid=1, from edge N onward.
  - out_data and out_valid are registered/pointer-derived, with no combinational path from writedata.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Pointers: DEPTH_LOG2 bits wide, wrap modulo 2**DEPTH_LOG2. count is DEPTH_LOG2+1 bits; full when count = 2**DEPTH_LOG2.
- Flush:
  - Clears pointers and count at the edge.
  - A push or pop in the same cycle is discarded; a push discarded this way does not set overflow.
  - overflow and irq_en are unaffected.
- OVFCLR:
  - Clears overflow.
  - If the same cycle also overflows: impossible, since there is a single Avalon port.
- irq:
  - Registered: irq <= irq_en & (empty_next | overflow_next).
  - Deasserts the cycle after the cause clears or irq_en is cleared.
- Reset mid-transfer: all state cleared immediately. Downstream must treat out_valid falling without handshake as abort.

Test Plan:
- Reset then idle: readdata=0, out_valid=0, irq=0. Read STATUS returns 0x00010000 (empty=1, count=0).
- DEPTH_LOG2=2, out_ready=0, write DATA 0x11,0x22,0x33,0x44 -> STATUS=0x00020004. out_data=0x11. 5th write 0x55 -> STATUS=0x00060004, FIFO contents unchanged.
- Then out_ready=1 for 4 cycles -> out_data sequence 0x11,0x22,0x33,0x44. out_valid drops after 4th pop. STATUS=0x00050000. OVFCLR write 1 -> STATUS=0x00010000.
- Full FIFO, DATA write 0x66 with out_ready=1 same cycle -> 0x11 popped, 0x66 accepted, count stays 4, no overflow. Pop order later ends ...0x44,0x66. Also wrap pointers ≥3 times with continuous push/pop -> order preserved.
- CTRL write 0x1 while empty -> irq=1 next cycle. DATA write -> irq=0 the cycle after push. Pops to empty -> irq re-asserts. CTRL write 0x0 -> irq=0.
- 3 words queued, CTRL write 0x3 (flush+irq_en) simultaneous with out_ready=1 -> count=0, out_valid=0, no word transferred, overflow unchanged, irq=1. Async reset asserted mid-stream -> all outputs 0 within the same cycle.
